ps2_frame_receiver: RTL

- Parametrised PS/2 device-to-host serial receiver running entirely on the system clock.
- Synchronises and glitch-filters the raw PS/2 clock/data pins and detects falling edges of the PS/2 clock.
- Deframes start/data/parity/stop bits with a configurable data width and parity mode, and detects timeouts.
- Delivers each good frame on a valid/ready interface with error and overrun reporting; sits between the PS/2 pads and the scancode layer.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_frame_receiver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // ones_odd is the XOR of every data bit and the parity bit.
    function automatic logic parity_ok(parity_mode_t mode, logic ones_odd);
        case (mode)
            PAR_ODD:  return ones_odd;
            PAR_EVEN: return !ones_odd;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only follows
// the pin after it has held a new level for FILTER_LEN consecutive cycles.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filt
);

    localparam int CW = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                // This is the FILTER_LEN-th consecutive disagreeing cycle.
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: filtered pins, falling-edge sampling, frame
// deframing with parity/stop/timeout checks, and a one-deep valid/ready output.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int           DATA_BITS   = 8,
    parameter parity_mode_t PARITY_MODE = PAR_ODD,
    parameter int           FILTER_LEN  = 8,
    parameter int           TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [DATA_BITS-1:0] code,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    logic filt_clk;
    logic filt_data;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_clk),
        .filt (filt_clk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_data),
        .filt (filt_data)
    );

    rx_state_t            state_q;
    logic [BW-1:0]        bitcnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q;
    logic [WW-1:0]        wdog_q;
    logic                 filt_clk_prev_q;
    logic [DATA_BITS-1:0] code_q;
    logic                 valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic sample_d;
    logic stop_ok_d;
    logic parity_good_d;
    logic deliver_d;

    assign sample_d      = filt_clk_prev_q & ~filt_clk;
    assign stop_ok_d     = (filt_data == STOP_BIT);
    assign parity_good_d = parity_ok(PARITY_MODE, (^shreg_q) ^ par_q);
    assign deliver_d     = sample_d && (state_q == STOP) && stop_ok_d && parity_good_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            bitcnt_q        <= '0;
            shreg_q         <= '0;
            par_q           <= 1'b0;
            wdog_q          <= '0;
            filt_clk_prev_q <= 1'b1;
            code_q          <= '0;
            valid_q         <= 1'b0;
            parity_err_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            filt_clk_prev_q <= filt_clk;
            parity_err_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            overrun_q       <= 1'b0;

            // A full register that is being drained this cycle can take the new word.
            if (deliver_d) begin
                if (!valid_q || ready) begin
                    code_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            if (state_q == IDLE) begin
                wdog_q <= '0;
                if (sample_d && filt_data == START_BIT) begin
                    state_q  <= DATA;
                    bitcnt_q <= '0;
                end
            end else if (sample_d) begin
                wdog_q <= '0;
                case (state_q)
                    DATA: begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bitcnt_q == BW'(i)) begin
                                shreg_q[i] <= filt_data;
                            end
                        end
                        if (bitcnt_q == BW'(DATA_BITS - 1)) begin
                            state_q <= (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        par_q   <= filt_data;
                        state_q <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        if (!stop_ok_d) begin
                            frame_err_q <= 1'b1;
                        end else if (!parity_good_d) begin
                            parity_err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                // The pulse lands in the cycle the watchdog would read TIMEOUT_CYC.
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
                wdog_q      <= '0;
            end else begin
                wdog_q <= wdog_q + 1'b1;
            end
        end
    end

    assign code       = code_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
